// File: rtl/reset_ctrl_if.sv
// Request/status bundle between the reset controller and the core-side logic.
// The controller side uses the slave modport; whatever drives the requests uses master.
interface reset_ctrl_if;
  logic       sysresetreq_i;
  logic       lockup_i;
  logic       lockup_rst_en_i;
  logic       wdt_expire_i;
  logic       cause_clr_i;
  logic       bus_rst_o;
  logic       core_rst_o;
  logic       ready_o;
  logic [3:0] cause_o;

  modport master (
    output sysresetreq_i, lockup_i, lockup_rst_en_i, wdt_expire_i, cause_clr_i,
    input  bus_rst_o, core_rst_o, ready_o, cause_o
  );

  modport slave (
    input  sysresetreq_i, lockup_i, lockup_rst_en_i, wdt_expire_i, cause_clr_i,
    output bus_rst_o, core_rst_o, ready_o, cause_o
  );
endinterface

// File: rtl/reset_ctrl.sv
// Staged reset sequencer: releases bus/peripheral reset, then core reset, and
// replays the hold sequence on core-originated requests while logging sticky causes.
module reset_ctrl #(
  parameter int POR_CYCLES   = 16,
  parameter int CORE_DELAY   = 4,
  parameter int SWRST_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  reset_ctrl_if.slave ctrl
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  generate
    if (POR_CYCLES < 1 || POR_CYCLES > CNT_MAX ||
        CORE_DELAY < 1 || CORE_DELAY > CNT_MAX ||
        SWRST_CYCLES < 1 || SWRST_CYCLES > CNT_MAX) begin : gBadParams
      $error("reset_ctrl: cycle parameters must lie in 1 .. 2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SWRST_CYCLES - 1);

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    BUS_REL  = 2'd1,
    RUN      = 2'd2,
    SW_HOLD  = 2'd3
  } state_t;

  logic [1:0]       r_sync;
  logic             w_srst;
  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
  logic             r_busRst;
  logic             r_coreRst;
  logic             r_ready;
  logic             w_busRstNext;
  logic             w_coreRstNext;
  logic             w_readyNext;
  logic [3:0]       r_cause;
  logic [3:0]       w_causeSet;
  logic [3:0]       w_causeNext;
  logic             w_lockupReq;
  logic             w_request;

  // Being set asynchronously, even a sub-cycle rst pulse restarts the whole sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], 1'b0};
    end
  end

  assign w_srst      = r_sync[1];
  assign w_lockupReq = ctrl.lockup_i & ctrl.lockup_rst_en_i;
  assign w_request   = (r_state == RUN) &&
                       (ctrl.sysresetreq_i || ctrl.wdt_expire_i || w_lockupReq);
  assign w_causeSet  = w_request ? {w_lockupReq, ctrl.wdt_expire_i, ctrl.sysresetreq_i, 1'b0}
                                 : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= POR_HOLD;
      r_count   <= '0;
      r_busRst  <= 1'b1;
      r_coreRst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_busRst  <= w_busRstNext;
      r_coreRst <= w_coreRstNext;
      r_ready   <= w_readyNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    case (r_state)
      POR_HOLD: begin
        if (w_srst) begin
          w_countNext = '0;
        end else if (r_count == POR_LAST) begin
          w_stateNext = BUS_REL;
          w_countNext = '0;
        end else begin
          w_countNext = r_count + 1'b1;
        end
      end
      BUS_REL: begin
        if (r_count == CORE_LAST) begin
          w_stateNext = RUN;
          w_countNext = '0;
        end else begin
          w_countNext = r_count + 1'b1;
        end
      end
      RUN: begin
        w_countNext = '0;
        if (w_request) begin
          w_stateNext = SW_HOLD;
        end
      end
      SW_HOLD: begin
        if (r_count == SW_LAST) begin
          w_stateNext = BUS_REL;
          w_countNext = '0;
        end else begin
          w_countNext = r_count + 1'b1;
        end
      end
      default: begin
        w_stateNext = POR_HOLD;
        w_countNext = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops on the same edge.
  always_comb begin
    w_busRstNext  = (w_stateNext == POR_HOLD) || (w_stateNext == SW_HOLD);
    w_coreRstNext = (w_stateNext != RUN);
    w_readyNext   = (w_stateNext == RUN);
  end

  assign w_causeNext = (ctrl.cause_clr_i ? 4'b0000 : r_cause) | w_causeSet;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cause <= 4'b0001;
    end else begin
      r_cause <= w_causeNext;
    end
  end

  assign ctrl.bus_rst_o  = r_busRst;
  assign ctrl.core_rst_o = r_coreRst;
  assign ctrl.ready_o    = r_ready;
  assign ctrl.cause_o    = r_cause;

endmodule
